// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types, default parameters and the round-robin search helper used by
//   the FIFO write-side arbiter (and reusable by the read-side scheduler).
//   Contents:
//     arb_state_t   : arbiter FSM state (ST_IDLE / ST_GRANT)
//     DEF_*         : default NUM_REQ / WIDTH / MAX_BURST
//     rr_pick()     : first set bit at or above ptr, modulo num
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_WIDTH     = 8;
   localparam int DEF_MAX_BURST = 4;

   // The search helper works on a fixed 8-wide vector, the largest supported
   // producer count; callers zero-extend narrower request vectors.
   localparam int PICK_MAX = 8;
   localparam int PICK_W   = 3;

   // Returns the index of the first set bit of valid, scanning ptr, ptr+1, ...
   // wrapping at num. The scan runs from the far end back toward ptr so that
   // the closest candidate overwrites all others. If nothing is set, ptr is
   // returned (callers qualify with their own any-valid flag).
   function automatic logic [PICK_W-1:0] rr_pick(
      input logic [PICK_MAX-1:0] valid,
      input logic [PICK_W-1:0]   ptr,
      input int                  num
   );
      int                cand;
      logic [PICK_W-1:0] pick;
      pick = ptr;
      for (int k = PICK_MAX - 1; k >= 0; k--) begin
         cand = int'(ptr) + k;
         if (cand >= num) begin
            cand = cand - num;
         end
         if ((k < num) && valid[PICK_W'(cand)]) begin
            pick = PICK_W'(cand);
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin search: finds the first asserted request at or
//   above a rotating pointer, wrapping modulo NUM_REQ.
//   Ports:
//     valid     in  [NUM_REQ-1:0]  request vector
//     ptr       in  [IDX_W-1:0]    search start index (must be < NUM_REQ)
//     any_valid out                at least one request is set
//     pick      out [IDX_W-1:0]    chosen index (meaningful when any_valid)
// ---------------------------------------------------------------------------
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any_valid,
   output logic [IDX_W-1:0]   pick
);

   logic [PICK_MAX-1:0] valid_ext;
   logic [PICK_W-1:0]   ptr_ext;

   // Zero-extend the request vector to the helper's fixed width.
   generate
      for (genvar gi = 0; gi < PICK_MAX; gi++) begin : g_ext
         if (gi < NUM_REQ) begin : g_live
            assign valid_ext[gi] = valid[gi];
         end else begin : g_pad
            assign valid_ext[gi] = 1'b0;
         end
      end
   endgenerate

   assign ptr_ext   = PICK_W'(ptr);
   assign any_valid = |valid;
   assign pick      = IDX_W'(rr_pick(valid_ext, ptr_ext, NUM_REQ));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing the FIFO write port among NUM_REQ producers.
//   A producer is granted for up to MAX_BURST beats, then the grant rotates.
//   Every grant is preceded by one IDLE arbitration cycle.
//   Ports:
//     clk         in   FIFO write clock (rising edge)
//     rst         in   synchronous active-high reset
//     req_valid   in   [NUM_REQ-1:0]        producer has data
//     req_data    in   [NUM_REQ*WIDTH-1:0]  producer i data at [i*WIDTH +: WIDTH]
//     req_ready   out  [NUM_REQ-1:0]        producer beat accepted this cycle
//     wr_en       out                       FIFO write enable
//     wr_data     out  [WIDTH-1:0]          FIFO write data (0 when idle)
//     full        in                        FIFO full flag
//     grant_id    out  [IDX_W-1:0]          granted producer (valid while busy)
//     busy        out                       a grant is active
//     beat_total  out  [15:0]               accepted beat count, wrapping
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int IDX_W     = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       wr_en,
   output logic [WIDTH-1:0]           wr_data,
   input  logic                       full,
   output logic [IDX_W-1:0]           grant_id,
   output logic                       busy,
   output logic [15:0]                beat_total
);

   localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   arb_state_t        state_reg, state_next;
   logic [IDX_W-1:0]  grant_id_reg;
   logic [IDX_W-1:0]  rr_ptr_reg;
   logic [BC_W-1:0]   beat_cnt_reg;
   logic [15:0]       beat_total_reg;

   logic              any_valid;
   logic [IDX_W-1:0]  pick;
   logic              cur_valid;
   logic              beat;
   logic              last_beat;
   logic              release_grant;
   logic [WIDTH-1:0]  data_arr [NUM_REQ];

   // -----------------------------------------------------------------------
   // Round-robin search from rr_ptr
   // -----------------------------------------------------------------------
   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .valid     (req_valid),
      .ptr       (rr_ptr_reg),
      .any_valid (any_valid),
      .pick      (pick)
   );

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data
         assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // A beat needs an active grant, a valid owner and room in the FIFO. It is
   // also suppressed while rst is high so a reset cycle never writes.
   assign cur_valid     = req_valid[grant_id_reg];
   assign beat          = (state_reg == ST_GRANT) && cur_valid && !full && !rst;
   assign last_beat     = beat && (beat_cnt_reg == LAST_BEAT);
   // A full stall with valid held keeps the grant; only a dropped valid or
   // the final beat of the burst releases it.
   assign release_grant = (state_reg == ST_GRANT) && (!cur_valid || last_beat);

   // -----------------------------------------------------------------------
   // FSM: state register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // -----------------------------------------------------------------------
   // FSM: next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (any_valid) begin
               state_next = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (release_grant) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // -----------------------------------------------------------------------
   // FSM: outputs (combinational from registered grant, valid and full)
   // -----------------------------------------------------------------------
   always_comb begin
      wr_en   = 1'b0;
      wr_data = '0;
      if (beat) begin
         wr_en   = 1'b1;
         wr_data = data_arr[grant_id_reg];
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = beat && (grant_id_reg == IDX_W'(gi));
      end
   endgenerate

   assign busy       = (state_reg == ST_GRANT);
   assign grant_id   = grant_id_reg;
   assign beat_total = beat_total_reg;

   // -----------------------------------------------------------------------
   // Grant, pointer and beat counters
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_id_reg   <= '0;
         rr_ptr_reg     <= '0;
         beat_cnt_reg   <= '0;
         beat_total_reg <= '0;
      end else begin
         if ((state_reg == ST_IDLE) && any_valid) begin
            grant_id_reg <= pick;
            beat_cnt_reg <= '0;
         end
         if (beat) begin
            beat_cnt_reg   <= beat_cnt_reg + 1'b1;
            beat_total_reg <= beat_total_reg + 16'd1;
         end
         if (release_grant) begin
            rr_ptr_reg <= (grant_id_reg == LAST_IDX) ? '0 : grant_id_reg + 1'b1;
         end
      end
   end

endmodule
